// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// a helper to size the bus-timeout counter.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // Bits needed to count from 0 up to max_count inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes / data replication and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: strobe placement and replication of the store operand.
    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend to 32 bits.
    always_comb begin
        w_byte  = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_rdata = i_rdata;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_HU:   o_rdata = {16'd0, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: accepts one request, checks legality and
// alignment, performs a single memory access with timeout, returns one response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_is_store,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_misaligned,
    output logic        o_resp_fault
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e r_state, w_state_next;

    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_resp_rdata;
    logic             r_resp_mis;
    logic             r_resp_fault;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_in_access;
    logic        w_timeout;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;

    lsu_align u_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (i_mem_rdata),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rdata)
    );

    assign w_accept    = i_req_valid && (r_state == IDLE);
    assign w_in_access = (r_state == ACCESS);
    // Ack on the final allowed cycle takes priority over the timeout.
    assign w_timeout   = w_in_access && !i_mem_ack && (r_cnt == CNT_LAST);

    // Legality and alignment of the captured request.
    always_comb begin
        w_illegal = 1'b1;
        case (r_funct3)
            F3_B, F3_H, F3_W: w_illegal = 1'b0;
            F3_BU, F3_HU:     w_illegal = r_is_store;
            default:          w_illegal = 1'b1;
        endcase
        w_misaligned = ((r_funct3 == F3_H || r_funct3 == F3_HU) && r_addr[0]) ||
                       ((r_funct3 == F3_W) && (r_addr[1:0] != 2'b00));
    end

    // Next-state and output decode.
    always_comb begin
        w_state_next      = r_state;
        o_req_ready       = 1'b0;
        o_mem_req         = 1'b0;
        o_mem_we          = 1'b0;
        o_mem_addr        = 32'd0;
        o_mem_wdata       = 32'd0;
        o_mem_wstrb       = 4'd0;
        o_resp_valid      = 1'b0;
        o_resp_rdata      = 32'd0;
        o_resp_misaligned = 1'b0;
        o_resp_fault      = 1'b0;
        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (w_accept) w_state_next = CHECK;
            end
            CHECK: begin
                w_state_next = (w_illegal || w_misaligned) ? RESP : ACCESS;
            end
            ACCESS: begin
                o_mem_req  = 1'b1;
                o_mem_we   = r_is_store;
                o_mem_addr = {r_addr[31:2], 2'b00};
                if (r_is_store) begin
                    o_mem_wdata = w_wdata;
                    o_mem_wstrb = w_wstrb;
                end
                if (i_mem_ack || w_timeout) w_state_next = RESP;
            end
            RESP: begin
                o_resp_valid      = 1'b1;
                o_resp_rdata      = r_resp_rdata;
                o_resp_misaligned = r_resp_mis;
                o_resp_fault      = r_resp_fault;
                w_state_next      = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Capture the request on acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
        end else if (w_accept) begin
            r_is_store <= i_req_is_store;
            r_funct3   <= i_req_funct3;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
        end
    end

    // Timeout counter: zero outside ACCESS, counts unacknowledged cycles inside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       r_cnt <= '0;
        else if (!w_in_access)            r_cnt <= '0;
        else if (!i_mem_ack && !w_timeout) r_cnt <= r_cnt + 1'b1;
    end

    // Response payload, latched on the transition into RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_rdata <= 32'd0;
            r_resp_mis   <= 1'b0;
            r_resp_fault <= 1'b0;
        end else if (r_state == CHECK) begin
            r_resp_rdata <= 32'd0;
            r_resp_fault <= w_illegal;
            r_resp_mis   <= !w_illegal && w_misaligned;
        end else if (w_in_access && i_mem_ack) begin
            r_resp_rdata <= r_is_store ? 32'd0 : w_rdata;
            r_resp_fault <= 1'b0;
            r_resp_mis   <= 1'b0;
        end else if (w_timeout) begin
            r_resp_rdata <= 32'd0;
            r_resp_fault <= 1'b1;
            r_resp_mis   <= 1'b0;
        end
    end

endmodule
